// File: rtl/rast_pkg.sv
// Shared definitions for the line rasterizer: FSM encoding, octant bit
// positions and the default coordinate width.
package rast_pkg;

    localparam int COORD_W_DEF = 10;

    // Bit positions inside line_octant = {steep, endpoints_swapped, ystep_neg}
    localparam int OCT_STEEP = 2;
    localparam int OCT_SWAP  = 1;
    localparam int OCT_YNEG  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } rast_state_t;

endpackage

// File: rtl/rast_octant_setup.sv
// Combinational normalisation of a segment to the first octant.
// Swaps axes for steep lines, orders the endpoints so the major axis
// increases, and derives the Bresenham step terms and the initial error.
module rast_octant_setup
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int ERR_W   = COORD_W + 3
) (
    input  logic [COORD_W-1:0]      x0,
    input  logic [COORD_W-1:0]      y0,
    input  logic [COORD_W-1:0]      x1,
    input  logic [COORD_W-1:0]      y1,
    output logic                    steep,
    output logic                    swapped,
    output logic                    ystep_neg,
    output logic [COORD_W-1:0]      sx0,
    output logic [COORD_W-1:0]      sy0,
    output logic [COORD_W-1:0]      sx1,
    output logic signed [ERR_W-1:0] dy2,
    output logic signed [ERR_W-1:0] dxy2,
    output logic signed [ERR_W-1:0] err_init
);

    logic [COORD_W-1:0]      dx;
    logic [COORD_W-1:0]      dy;
    logic [COORD_W-1:0]      ax0;
    logic [COORD_W-1:0]      ay0;
    logic [COORD_W-1:0]      ax1;
    logic [COORD_W-1:0]      ay1;
    logic [COORD_W-1:0]      sy1;
    logic [COORD_W-1:0]      d_major;
    logic [COORD_W-1:0]      d_minor;
    logic signed [ERR_W-1:0] maj_e;
    logic signed [ERR_W-1:0] min_e;

    // Absolute deltas decide which axis is the major (stepping) axis
    assign dx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign dy    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    assign steep = (dy > dx);

    // Steep lines are drawn with x and y exchanged
    assign ax0 = steep ? y0 : x0;
    assign ay0 = steep ? x0 : y0;
    assign ax1 = steep ? y1 : x1;
    assign ay1 = steep ? x1 : y1;

    // Order endpoints so the major coordinate only ever increments
    assign swapped = (ax0 > ax1);
    assign sx0     = swapped ? ax1 : ax0;
    assign sy0     = swapped ? ay1 : ay0;
    assign sx1     = swapped ? ax0 : ax1;
    assign sy1     = swapped ? ay0 : ay1;

    assign ystep_neg = (sy1 < sy0);
    assign d_major   = sx1 - sx0;
    assign d_minor   = ystep_neg ? (sy0 - sy1) : (sy1 - sy0);

    // Zero-extend into the wider signed domain so 2*delta never wraps
    assign maj_e    = $signed({{(ERR_W-COORD_W){1'b0}}, d_major});
    assign min_e    = $signed({{(ERR_W-COORD_W){1'b0}}, d_minor});
    assign dy2      = min_e + min_e;
    assign err_init = dy2 - maj_e;
    assign dxy2     = dy2 - maj_e - maj_e;

endmodule

// File: rtl/line_rasterizer.sv
// Line segment rasterizer: accepts one segment per handshake, normalises it
// in a single SETUP cycle, then streams one Bresenham pixel per cycle in
// original screen coordinates with valid/ready backpressure.
module line_rasterizer
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic [2:0]         line_octant,
    output logic               busy
);

    localparam int ERR_W = COORD_W + 3;

    rast_state_t state_reg, state_next;

    logic [COORD_W-1:0]      x0_reg, x0_next;
    logic [COORD_W-1:0]      y0_reg, y0_next;
    logic [COORD_W-1:0]      x1_reg, x1_next;
    logic [COORD_W-1:0]      y1_reg, y1_next;
    logic [COORD_W-1:0]      major_reg, major_next;
    logic [COORD_W-1:0]      minor_reg, minor_next;
    logic [COORD_W-1:0]      end_reg, end_next;
    logic signed [ERR_W-1:0] err_reg, err_next;
    logic signed [ERR_W-1:0] dy2_reg, dy2_next;
    logic signed [ERR_W-1:0] dxy2_reg, dxy2_next;
    logic [2:0]              octant_reg, octant_next;

    logic                    s_steep;
    logic                    s_swapped;
    logic                    s_ystep_neg;
    logic [COORD_W-1:0]      s_sx0;
    logic [COORD_W-1:0]      s_sy0;
    logic [COORD_W-1:0]      s_sx1;
    logic signed [ERR_W-1:0] s_dy2;
    logic signed [ERR_W-1:0] s_dxy2;
    logic signed [ERR_W-1:0] s_err_init;

    logic                    at_end;
    logic                    err_pos;

    rast_octant_setup #(
        .COORD_W (COORD_W),
        .ERR_W   (ERR_W)
    ) u_setup (
        .x0        (x0_reg),
        .y0        (y0_reg),
        .x1        (x1_reg),
        .y1        (y1_reg),
        .steep     (s_steep),
        .swapped   (s_swapped),
        .ystep_neg (s_ystep_neg),
        .sx0       (s_sx0),
        .sy0       (s_sy0),
        .sx1       (s_sx1),
        .dy2       (s_dy2),
        .dxy2      (s_dxy2),
        .err_init  (s_err_init)
    );

    assign at_end  = (major_reg == end_reg);
    assign err_pos = !err_reg[ERR_W-1] && (err_reg != '0);

    // State and datapath registers; reset abandons any segment in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            x0_reg     <= '0;
            y0_reg     <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            major_reg  <= '0;
            minor_reg  <= '0;
            end_reg    <= '0;
            err_reg    <= '0;
            dy2_reg    <= '0;
            dxy2_reg   <= '0;
            octant_reg <= '0;
        end else begin
            state_reg  <= state_next;
            x0_reg     <= x0_next;
            y0_reg     <= y0_next;
            x1_reg     <= x1_next;
            y1_reg     <= y1_next;
            major_reg  <= major_next;
            minor_reg  <= minor_next;
            end_reg    <= end_next;
            err_reg    <= err_next;
            dy2_reg    <= dy2_next;
            dxy2_reg   <= dxy2_next;
            octant_reg <= octant_next;
        end
    end

    // Next-state logic: accept, one-cycle setup, then Bresenham stepping
    always_comb begin
        state_next  = state_reg;
        x0_next     = x0_reg;
        y0_next     = y0_reg;
        x1_next     = x1_reg;
        y1_next     = y1_reg;
        major_next  = major_reg;
        minor_next  = minor_reg;
        end_next    = end_reg;
        err_next    = err_reg;
        dy2_next    = dy2_reg;
        dxy2_next   = dxy2_reg;
        octant_next = octant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    x0_next    = x0;
                    y0_next    = y0;
                    x1_next    = x1;
                    y1_next    = y1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                major_next             = s_sx0;
                minor_next             = s_sy0;
                end_next               = s_sx1;
                err_next               = s_err_init;
                dy2_next               = s_dy2;
                dxy2_next              = s_dxy2;
                octant_next[OCT_STEEP] = s_steep;
                octant_next[OCT_SWAP]  = s_swapped;
                octant_next[OCT_YNEG]  = s_ystep_neg;
                state_next             = ST_DRAW;
            end
            ST_DRAW: begin
                if (pix_ready) begin
                    if (at_end) begin
                        state_next = ST_IDLE;
                    end else begin
                        major_next = major_reg + 1'b1;
                        if (err_pos) begin
                            minor_next = octant_reg[OCT_YNEG] ? (minor_reg - 1'b1)
                                                              : (minor_reg + 1'b1);
                            err_next   = err_reg + dxy2_reg;
                        end else begin
                            err_next   = err_reg + dy2_reg;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign busy        = (state_reg != ST_IDLE);
    assign pix_valid   = (state_reg == ST_DRAW);
    assign pix_last    = (state_reg == ST_DRAW) && at_end;
    assign pix_x       = octant_reg[OCT_STEEP] ? minor_reg : major_reg;
    assign pix_y       = octant_reg[OCT_STEEP] ? major_reg : minor_reg;
    assign line_octant = octant_reg;

endmodule
